// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU types, load/store access widths and LSU states
package cpu_pkg;

  typedef logic [31:0] cpu_word;
  typedef logic [4:0]  reg_select;

  typedef enum logic [1:0] {MEM_W, MEM_H, MEM_B} mem_mode;

  typedef enum logic [1:0] {LSU_IDLE, LSU_LOAD_WAIT, LSU_STORE_WAIT} lsu_state;

  localparam int CNT_W = 8;

  // True when the access width does not divide the byte address
  function automatic logic misaligned(mem_mode m, logic [1:0] a);
    return (m == MEM_H && a[0]) || (m == MEM_W && a != 2'b00);
  endfunction

endpackage

// File: rtl/load_extend.sv
// load_extend: sign-/zero-extension of zero-extended RAM load data
module load_extend
  import cpu_pkg::*;
(
  input  cpu_word port2o,
  input  mem_mode mode,
  input  logic    sgn,
  output cpu_word data
);

  // Replicate the top bit of the accessed byte/halfword only on signed narrow loads
  always_comb
    data = !sgn            ? port2o :
           (mode == MEM_B) ? {{24{port2o[7]}}, port2o[7:0]} :
           (mode == MEM_H) ? {{16{port2o[15]}}, port2o[15:0]} : port2o;

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store initiator on the RAM data port.
// Optional LSU_ALIGN_CHECK_EN rejects misaligned halfword/word accesses with a fault.
module load_store_unit
  import cpu_pkg::*;
#(
  parameter int STORE_CYCLES = 2,
  parameter int WATCHDOG     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  mem_mode     req_mode,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        req_ready,
  input  logic        iRegAvail,
  output logic        port2en,
  output logic        port2WEn,
  output logic [31:0] port2adr,
  output logic [31:0] port2i,
  output mem_mode     memMode,
  input  logic [31:0] port2o,
  input  logic        port2avail,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        done,
  output logic        busy,
  output logic        fault
);

  lsu_state         state_q, state_d;
  logic [CNT_W-1:0] counter_q, counter_d;
  reg_select        rd_q, rd_d;
  mem_mode          mode_q, mode_d;
  logic             signed_q, signed_d;
  logic             wb_we_q, wb_we_d;
  reg_select        wb_rd_q, wb_rd_d;
  cpu_word          wb_data_q, wb_data_d;
  logic             done_q, done_d;
  logic             fault_q, fault_d;
  logic             issue, bad;
  cpu_word          ext_data;

  load_extend u_extend (
    .port2o (port2o),
    .mode   (mode_q),
    .sgn    (signed_q),
    .data   (ext_data)
  );

  // Request handshake: only from idle while the RAM is free; misaligned accesses never reach RAM
  always_comb begin
    issue     = (state_q == LSU_IDLE) & req_valid & iRegAvail;
`ifdef LSU_ALIGN_CHECK_EN
    bad       = misaligned(req_mode, req_addr[1:0]);
`else
    bad       = 1'b0;
`endif
    req_ready = issue;
    port2en   = issue & ~bad;
    port2WEn  = req_we;
    port2adr  = req_addr;
    port2i    = req_wdata;
    memMode   = req_mode;
  end

  // Next state: track the RAM response, run watchdog / store countdown, build one-cycle pulses
  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    rd_d      = rd_q;
    mode_d    = mode_q;
    signed_d  = signed_q;
    wb_we_d   = 1'b0;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    done_d    = 1'b0;
    fault_d   = fault_q;
    case (state_q)
      LSU_IDLE:
        if (issue) begin
          rd_d     = req_rd;
          mode_d   = req_mode;
          signed_d = req_signed;
          fault_d  = 1'b0;
          if (bad) begin
            fault_d = 1'b1;
            done_d  = 1'b1;
          end else if (req_we) begin
            state_d   = LSU_STORE_WAIT;
            counter_d = CNT_W'(STORE_CYCLES - 1);
          end else begin
            state_d   = LSU_LOAD_WAIT;
            counter_d = '0;
          end
        end
      LSU_LOAD_WAIT:
        if (port2avail) begin
          wb_data_d = ext_data;
          wb_rd_d   = rd_q;
          wb_we_d   = 1'b1;
          done_d    = 1'b1;
          state_d   = LSU_IDLE;
        end else if (counter_q == CNT_W'(WATCHDOG - 1)) begin
          fault_d = 1'b1;
          done_d  = 1'b1;
          state_d = LSU_IDLE;
        end else begin
          counter_d = counter_q + 1'b1;
        end
      LSU_STORE_WAIT:
        if (counter_q <= CNT_W'(1)) begin
          counter_d = '0;
          done_d    = 1'b1;
          state_d   = LSU_IDLE;
        end else begin
          counter_d = counter_q - 1'b1;
        end
      default: state_d = LSU_IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously so a reset aborts any access at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= LSU_IDLE;
      counter_q <= '0;
      rd_q      <= '0;
      mode_q    <= MEM_W;
      signed_q  <= 1'b0;
      wb_we_q   <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
      done_q    <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      rd_q      <= rd_d;
      mode_q    <= mode_d;
      signed_q  <= signed_d;
      wb_we_q   <= wb_we_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
      done_q    <= done_d;
      fault_q   <= fault_d;
    end
  end

  assign wb_we   = wb_we_q;
  assign wb_rd   = wb_rd_q;
  assign wb_data = wb_data_q;
  assign done    = done_q;
  assign fault   = fault_q;
  assign busy    = (state_q != LSU_IDLE);

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed + randomized checks of load_store_unit against a byte-memory model
module tb_load_store_unit;
  import cpu_pkg::*;

  localparam int WD = 16;

  logic        clk = 1'b0, reset = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0;
  mem_mode     req_mode = MEM_W;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [4:0]  req_rd = '0;
  logic        req_ready, iRegAvail = 1'b1;
  logic        port2en, port2WEn;
  logic [31:0] port2adr, port2i;
  mem_mode     memMode;
  logic [31:0] port2o = '0;
  logic        port2avail = 1'b0;
  logic        wb_we, done, busy, fault;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int tests = 0, errors = 0;
  logic [7:0] ram   [0:1023];
  logic [7:0] model [0:1023];
  logic ram_mute = 1'b0;

  load_store_unit #(.STORE_CYCLES(2), .WATCHDOG(WD)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we), .req_mode(req_mode),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .req_ready(req_ready), .iRegAvail(iRegAvail), .port2en(port2en), .port2WEn(port2WEn),
    .port2adr(port2adr), .port2i(port2i), .memMode(memMode), .port2o(port2o),
    .port2avail(port2avail), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .done(done),
    .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  function automatic int nbytes(mem_mode m);
    return m == MEM_B ? 1 : m == MEM_H ? 2 : 4;
  endfunction

  // RAM emulation: answers a load one cycle after the strobe, rewrites stores
  always @(posedge clk) begin
    port2avail <= 1'b0;
    if (port2en) begin
      int n, base;
      logic [31:0] v;
      n = nbytes(memMode);
      base = int'(port2adr[9:0]) / n * n;
      v = '0;
      for (int k = 0; k < n; k++) begin
        if (port2WEn) ram[base + k] <= port2i[8*k +: 8];
        v[8*k +: 8] = ram[base + k];
      end
      if (!port2WEn && !ram_mute) begin
        port2o     <= v;
        port2avail <= 1'b1;
      end
    end
  end

  function automatic logic [31:0] model_load(logic [31:0] a, mem_mode m, logic sgn);
    int n = nbytes(m);
    int base = int'(a % 1024) / n * n;
    longint v = 0;
    for (int k = 0; k < n; k++) v += longint'(model[base + k]) * (longint'(1) << (8 * k));
    if (sgn && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
    return 32'(v);
  endfunction

  function automatic void model_store(logic [31:0] a, mem_mode m, logic [31:0] d);
    int n = nbytes(m);
    int base = int'(a % 1024) / n * n;
    for (int k = 0; k < n; k++) model[base + k] = 8'((d >> (8 * k)) % 256);
  endfunction

  task automatic do_access(input logic we, input mem_mode m, input logic sgn, input logic [31:0] a,
                           input logic [31:0] wd, input logic [4:0] rd, output int lat,
                           output int wbn, output logic [31:0] wdat, output logic [4:0] wrd,
                           output logic flt, output logic p2en);
    int t = 0;
    lat = -1; wbn = 0; wdat = 'x; wrd = 'x; flt = 'x; p2en = 'x;
    req_we = we; req_mode = m; req_signed = sgn; req_addr = a; req_wdata = wd; req_rd = rd;
    req_valid = 1'b1;
    @(negedge clk);
    while (!req_ready && t < 50) begin @(negedge clk); t++; end
    if (!req_ready) begin
      tests++; errors++;
      $display("FAIL accept_timeout: req_ready=%b required 1", req_ready);
      req_valid = 1'b0;
      return;
    end
    p2en = port2en;
    @(posedge clk); #1 req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (wb_we) begin wbn++; wdat = wb_data; wrd = wb_rd; end
    end while (!done && lat < 60);
    flt = fault;
    if (!done) begin
      tests++; errors++;
      $display("FAIL done_timeout: done=%b required 1 within 60 cycles", done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests += 7;
    if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (done !== 1'b0)    begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    if (wb_we !== 1'b0)   begin errors++; $display("FAIL reset_wb_we: got %b want 0", wb_we); end
    if (fault !== 1'b0)   begin errors++; $display("FAIL reset_fault: got %b want 0", fault); end
    if (wb_data !== '0)   begin errors++; $display("FAIL reset_wb_data: got %h want 0", wb_data); end
    if (wb_rd !== '0)     begin errors++; $display("FAIL reset_wb_rd: got %0d want 0", wb_rd); end
    if (port2en !== 1'b0) begin errors++; $display("FAIL reset_port2en: got %b want 0", port2en); end
    @(posedge clk); #1 reset = 1'b1;
  endtask

  task automatic test_directed();
    int lat, wbn; logic [31:0] d; logic [4:0] r; logic f, p;
    ram[10'h102] = 8'h01; model[10'h102] = 8'h01;
    ram[10'h103] = 8'h80; model[10'h103] = 8'h80;
    do_access(1'b0, MEM_B, 1'b1, 32'h103, '0, 5'd5, lat, wbn, d, r, f, p);
    tests += 4;
    if (d !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_signed_data: got %h want ffffff80", d); end
    if (lat !== 2)          begin errors++; $display("FAIL lb_latency: got %0d want 2", lat); end
    if (wbn !== 1)          begin errors++; $display("FAIL lb_wb_count: got %0d want 1", wbn); end
    if (p !== 1'b1)         begin errors++; $display("FAIL lb_port2en: got %b want 1", p); end
    do_access(1'b0, MEM_H, 1'b0, 32'h102, '0, 5'd9, lat, wbn, d, r, f, p);
    tests += 2;
    if (d !== 32'h00008001) begin errors++; $display("FAIL lh_unsigned_data: got %h want 00008001", d); end
    if (r !== 5'd9)         begin errors++; $display("FAIL lh_wb_rd: got %0d want 9", r); end
    do_access(1'b1, MEM_W, 1'b0, 32'h200, 32'hDEADBEEF, 5'd1, lat, wbn, d, r, f, p);
    model_store(32'h200, MEM_W, 32'hDEADBEEF);
    tests += 2;
    if (lat !== 2) begin errors++; $display("FAIL sw_latency: got %0d want 2", lat); end
    if (wbn !== 0) begin errors++; $display("FAIL sw_no_wb: got %0d want 0", wbn); end
    do_access(1'b0, MEM_W, 1'b0, 32'h200, '0, 5'd0, lat, wbn, d, r, f, p);
    tests += 2;
    if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_after_sw: got %h want deadbeef", d); end
    if (wbn !== 1)          begin errors++; $display("FAIL lw_rd0_wb_we: got %0d want 1", wbn); end
  endtask

  task automatic test_stall();
    int t = 0;
    iRegAvail = 1'b0;
    req_we = 1'b0; req_mode = MEM_W; req_signed = 1'b0; req_addr = 32'h200; req_rd = 5'd3;
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (req_ready !== 1'b0 || port2en !== 1'b0) begin
        errors++; $display("FAIL stall_%0d: ready=%b port2en=%b want 0/0", i, req_ready, port2en);
      end
    end
    @(posedge clk); #1 iRegAvail = 1'b1;
    @(negedge clk);
    tests++;
    if (req_ready !== 1'b1 || port2en !== 1'b1) begin
      errors++; $display("FAIL stall_release: ready=%b port2en=%b want 1/1", req_ready, port2en);
    end
    @(posedge clk); #1 req_valid = 1'b0;
    while (!done && t < 30) begin @(negedge clk); t++; end
    tests++;
    if (wb_data !== model_load(32'h200, MEM_W, 1'b0)) begin
      errors++; $display("FAIL stall_data: got %h want %h", wb_data, model_load(32'h200, MEM_W, 1'b0));
    end
  endtask

  task automatic test_watchdog();
    int lat, wbn; logic [31:0] d; logic [4:0] r; logic f, p;
    ram_mute = 1'b1;
    do_access(1'b0, MEM_W, 1'b0, 32'h40, '0, 5'd7, lat, wbn, d, r, f, p);
    ram_mute = 1'b0;
    tests += 3;
    if (lat !== WD + 1) begin errors++; $display("FAIL wd_latency: got %0d want %0d", lat, WD + 1); end
    if (f !== 1'b1)     begin errors++; $display("FAIL wd_fault: got %b want 1", f); end
    if (wbn !== 0)      begin errors++; $display("FAIL wd_no_wb: got %0d want 0", wbn); end
    @(negedge clk);
    tests++;
    if (fault !== 1'b1) begin errors++; $display("FAIL wd_fault_sticky: got %b want 1", fault); end
    do_access(1'b1, MEM_B, 1'b0, 32'h41, 32'h5A, 5'd0, lat, wbn, d, r, f, p);
    model_store(32'h41, MEM_B, 32'h5A);
    tests++;
    if (f !== 1'b0) begin errors++; $display("FAIL wd_fault_cleared: got %b want 0", f); end
  endtask

  task automatic test_back_to_back();
    int t = 0; logic seen = 1'b0;
    logic [31:0] v = $urandom;
    req_we = 1'b1; req_mode = MEM_W; req_signed = 1'b0; req_addr = 32'h300; req_wdata = v; req_rd = 5'd0;
    req_valid = 1'b1;
    @(negedge clk);
    while (!req_ready && t < 20) begin @(negedge clk); t++; end
    @(posedge clk); #1;
    model_store(32'h300, MEM_W, v);
    req_we = 1'b0; req_rd = 5'd12;
    t = 0;
    while (!seen && t < 20) begin
      @(negedge clk); t++;
      if (req_ready) begin
        seen = 1'b1;
        tests++;
        if (done !== 1'b1) begin errors++; $display("FAIL b2b_ready_with_done: done=%b want 1", done); end
      end
    end
    tests++;
    if (!seen) begin errors++; $display("FAIL b2b_accept: req_ready=0 want 1 within 20 cycles"); end
    @(posedge clk); #1 req_valid = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (!wb_we && t < 20);
    tests++;
    if (wb_data !== v || wb_rd !== 5'd12) begin
      errors++; $display("FAIL b2b_load: got %h/%0d want %h/12", wb_data, wb_rd, v);
    end
  endtask

  task automatic test_reset_mid();
    int t = 0;
    ram_mute = 1'b1;
    req_we = 1'b0; req_mode = MEM_W; req_addr = 32'h80; req_rd = 5'd4; req_valid = 1'b1;
    @(negedge clk);
    while (!req_ready && t < 20) begin @(negedge clk); t++; end
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b want 1", busy); end
    reset = 1'b0;
    #1;
    tests += 2;
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy: got %b want 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL mid_reset_done: got %b want 0", done); end
    @(posedge clk); #1 reset = 1'b1; ram_mute = 1'b0;
  endtask

`ifdef LSU_ALIGN_CHECK_EN
  task automatic test_align();
    int lat, wbn; logic [31:0] d; logic [4:0] r; logic f, p;
    do_access(1'b0, MEM_W, 1'b0, 32'h202, '0, 5'd6, lat, wbn, d, r, f, p);
    tests += 4;
    if (p !== 1'b0)  begin errors++; $display("FAIL align_port2en: got %b want 0", p); end
    if (f !== 1'b1)  begin errors++; $display("FAIL align_fault: got %b want 1", f); end
    if (lat !== 1)   begin errors++; $display("FAIL align_latency: got %0d want 1", lat); end
    if (wbn !== 0)   begin errors++; $display("FAIL align_no_wb: got %0d want 0", wbn); end
  endtask
`endif

  task automatic test_random();
    int lat, wbn; logic [31:0] d; logic [4:0] r; logic f, p;
    for (int i = 0; i < 40; i++) begin
      logic we = 1'($urandom_range(0, 1));
      mem_mode m = mem_mode'($urandom_range(0, 2));
      logic sgn = 1'($urandom_range(0, 1));
      logic [31:0] a = 32'($urandom_range(0, 63) / nbytes(m) * nbytes(m) + 32'h380);
      logic [31:0] wd = $urandom;
      logic [4:0] rd = 5'($urandom_range(0, 31));
      logic [31:0] exp = model_load(a, m, sgn);
      do_access(we, m, sgn, a, wd, rd, lat, wbn, d, r, f, p);
      tests += 2;
      if (lat !== 2) begin errors++; $display("FAIL rand_latency_%0d: got %0d want 2", i, lat); end
      if (f !== 1'b0) begin errors++; $display("FAIL rand_fault_%0d: got %b want 0", i, f); end
      if (we) begin
        model_store(a, m, wd);
        tests++;
        if (wbn !== 0) begin errors++; $display("FAIL rand_store_wb_%0d: got %0d want 0", i, wbn); end
      end else begin
        tests++;
        if (wbn !== 1 || d !== exp || r !== rd) begin
          errors++;
          $display("FAIL rand_load_%0d: got wb=%0d data=%h rd=%0d want 1/%h/%0d", i, wbn, d, r, exp, rd);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram[i] = 8'($urandom);
      model[i] = ram[i];
    end
    test_reset();
    test_directed();
    test_stall();
    test_watchdog();
    test_back_to_back();
    test_reset_mid();
`ifdef LSU_ALIGN_CHECK_EN
    test_align();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
